vote_ballot_collector: RTL and testbench
========================================

# vote_ballot_collector

Collects one ballot per voter from four voters over a shared cast bus, closes the ballot when all four have voted or a timeout expires, and presents the locked 4-bit ballot vector with a valid/ack handshake. Sits directly upstream of the 4-voter majority decoder: output `I[3:0]` drives that decoder's `I` input, and bit n is 1 when voter n voted yes. Absent voters count as no.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of cycles the ballot stays open; legal range 2..255.
- `CNT_W`, 8: width of the open-window cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: opens a new ballot; honoured only in IDLE.
- `cast_valid` input 1: a cast is presented this cycle.
- `cast_id` input 2: voter index 0..3.
- `cast_yes` input 1: 1 = yes, 0 = no.
- `I` output 4: ballot vector to the majority decoder; bit n = voter n yes.
- `voted` output 4: bit n = voter n has cast in the current or last ballot.
- `busy` output 1: high while the ballot is open (state OPEN).
- `ballot_valid` output 1: ballot closed and `I` is final; held until acknowledged.
- `ballot_ack` input 1: consumer has taken the ballot.
- `timed_out` output 1: ballot closed by timeout rather than a full turnout; valid while `ballot_valid` is high.
- `dup_cast` output 1: one-cycle pulse, registered, indicating a repeat cast was rejected.

## Operation
- Three states: IDLE, OPEN and DONE. All outputs are registered.
- **Reset:** state goes to IDLE. `I`, `voted`, `busy`, `ballot_valid`, `timed_out` and `dup_cast` all become 0, and the counter becomes 0. A reset during OPEN or DONE discards the ballot.
- **IDLE:**
  - `start` clears `I`, `voted`, `timed_out` and the counter, then moves to OPEN.
  - Casts are ignored.
  - `I` and `voted` keep the values from the last ballot.
- **OPEN, cast from a voter who has not voted** (`cast_valid` with `voted[cast_id]`=0): `I[cast_id]` <= `cast_yes` and `voted[cast_id]` <= 1.
- **OPEN, repeat cast** (`voted[cast_id]`=1): the cast is ignored and `dup_cast` pulses for one cycle.
- **OPEN, counter:** increments each OPEN cycle.
- **OPEN, full-turnout close:** if the voted mask including this cycle's cast equals 1111, go to DONE with `timed_out`=0.
- **OPEN, timeout close:** otherwise, if counter == TIMEOUT-1, go to DONE with `timed_out`=1. A cast arriving in that final cycle is still accepted. If that cast completes the turnout, the close counts as full turnout and `timed_out`=0.
- **DONE:**
  - `ballot_valid`=1.
  - `I`, `voted` and `timed_out` are frozen.
  - Casts are ignored silently, with no `dup_cast`. `start` is ignored.
  - `ballot_ack` returns the block to IDLE, and `ballot_valid` drops on the next edge.
  - `ballot_ack` outside DONE has no effect.
- `busy` = (state == OPEN).

## Timing
- `start` sampled at edge k: `busy`=1 from k+1. Casts are accepted at edges k+1 .. k+TIMEOUT.
- Latency from the accepting edge of the completing (4th distinct) cast to `ballot_valid`=1: 1 cycle. `I` is final in that same cycle.
- Timeout with no casts: `ballot_valid` rises TIMEOUT cycles after `busy` rises, and `I`=0000.
- `dup_cast` is high during the cycle after the rejected cast's edge.
- Minimum round trip, `start` to IDLE again: 4 distinct casts require at least 4 OPEN cycles, plus 1 DONE cycle when acked immediately.
- `ballot_ack` and `start` high together in DONE: the ack is taken and the block goes to IDLE. That `start` is not remembered; a new `start` is needed in IDLE.

## Configuration
- Macro `VOTE_REVOTE_EN`.
- **Defined:** a repeat cast while OPEN overwrites `I[cast_id]` with the new `cast_yes`. `voted` is unchanged and `dup_cast` stays 0.
- **Not defined:** first cast wins, and repeat casts pulse `dup_cast`.
- In both builds, DONE ignores all casts.

## Test plan
- Reset then start. Casts (0,yes), (1,no), (2,yes), (3,yes) on consecutive cycles -> `ballot_valid`=1 one cycle after the 4th cast, `I`=1101, `timed_out`=0, `voted`=1111.
- TIMEOUT=16. Start, then only (1,yes) and (3,yes) -> `ballot_valid` 16 cycles after `busy` rises, `I`=1010, `timed_out`=1, `voted`=1010.
- Repeat cast:
  - Without `VOTE_REVOTE_EN`: (2,yes) then (2,no) -> `I[2]`=1 and a single-cycle `dup_cast`.
  - With `VOTE_REVOTE_EN`: `I[2]`=0 and no `dup_cast`.
- 4th distinct cast lands exactly in the final open cycle (counter == TIMEOUT-1) -> close with `timed_out`=0 and all four bits captured.
- In DONE, hold `ballot_ack`=0 for 5 cycles while driving casts -> `I` and `ballot_valid` stable. Then `ballot_ack`=1 together with `start`=1 -> IDLE next cycle, `busy` stays 0.
- Assert `rst` mid-OPEN after 2 casts -> next cycle all outputs 0 and state IDLE. A following `start` opens a fresh ballot with `voted`=0000.

Source files
------------

// File: rtl/vote_ballot_collector.sv
// Four-voter ballot collector: 1-cycle cast-to-valid latency, result held until ballot_ack; VOTE_REVOTE_EN lets repeat casts overwrite.
// Closes on full turnout or after TIMEOUT open cycles; I drives the majority decoder.
module vote_ballot_collector #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cast_valid,
    input  logic [1:0] cast_id,
    input  logic       cast_yes,
    output logic [3:0] I,
    output logic [3:0] voted,
    output logic       busy,
    output logic       ballot_valid,
    input  logic       ballot_ack,
    output logic       timed_out,
    output logic       dup_cast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       i_nxt, voted_nxt;
    logic             to_nxt, dup_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        i_nxt     = I;
        voted_nxt = voted;
        to_nxt    = timed_out;
        dup_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    i_nxt     = 4'b0000;
                    voted_nxt = 4'b0000;
                    to_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = OPEN;
                end
            end
            OPEN: begin
                cnt_nxt = cnt + 1'b1;
                if (cast_valid) begin
                    if (!voted[cast_id]) begin
                        i_nxt[cast_id]     = cast_yes;
                        voted_nxt[cast_id] = 1'b1;
                    end else begin
`ifdef VOTE_REVOTE_EN
                        i_nxt[cast_id] = cast_yes;
`else
                        dup_nxt = 1'b1;
`endif
                    end
                end
                // Full turnout takes priority, so a completing cast in the last cycle is not a timeout.
                if (voted_nxt == 4'b1111) begin
                    to_nxt    = 1'b0;
                    state_nxt = DONE;
                end else if (cnt == LAST_CNT) begin
                    to_nxt    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (ballot_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            I            <= 4'b0000;
            voted        <= 4'b0000;
            timed_out    <= 1'b0;
            dup_cast     <= 1'b0;
            busy         <= 1'b0;
            ballot_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            I            <= i_nxt;
            voted        <= voted_nxt;
            timed_out    <= to_nxt;
            dup_cast     <= dup_nxt;
            busy         <= (state_nxt == OPEN);
            ballot_valid <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed test-plan scenarios plus random traffic, checked against a ballot-level reference model.
module tb_vote_ballot_collector;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst, start, cast_valid, cast_yes, ballot_ack;
    logic [1:0] cast_id;
    logic [3:0] I, voted;
    logic       busy, ballot_valid, timed_out, dup_cast;

    vote_ballot_collector #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cast_valid(cast_valid),
        .cast_id(cast_id), .cast_yes(cast_yes), .I(I), .voted(voted),
        .busy(busy), .ballot_valid(ballot_valid), .ballot_ack(ballot_ack),
        .timed_out(timed_out), .dup_cast(dup_cast)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: phase 0 = no ballot, 1 = collecting, 2 = result waiting
    int       m_phase   = 0;
    int       m_elapsed = 0;
    bit [3:0] m_yes     = 0;
    bit [3:0] m_cast    = 0;
    bit       m_to      = 0;
    bit       m_dup     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit cv, input int id,
                              input bit y, input bit a);
        m_dup = 0;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_yes = 0; m_cast = 0; m_to = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1; m_elapsed = 0; m_yes = 0; m_cast = 0; m_to = 0;
            end
        end else if (m_phase == 1) begin
            if (cv) begin
                if (m_cast[id] == 0) begin
                    m_cast[id] = 1;
                    m_yes[id]  = y;
                end else begin
`ifdef VOTE_REVOTE_EN
                    m_yes[id] = y;
`else
                    m_dup = 1;
`endif
                end
            end
            m_elapsed++;
            if (m_cast == 4'hF) begin
                m_phase = 2; m_to = 0;
            end else if (m_elapsed == TIMEOUT) begin
                m_phase = 2; m_to = 1;
            end
        end else begin
            if (a) m_phase = 0;
        end
    endtask

    task automatic check_all();
        chk("I", I, m_yes);
        chk("voted", voted, m_cast);
        chk("busy", busy, m_phase == 1);
        chk("ballot_valid", ballot_valid, m_phase == 2);
        chk("timed_out", timed_out, m_to);
        chk("dup_cast", dup_cast, m_dup);
    endtask

    task automatic cyc(input bit r, input bit s, input bit cv, input int id,
                       input bit y, input bit a);
        rst = r; start = s; cast_valid = cv; cast_id = 2'(id); cast_yes = y; ballot_ack = a;
        @(posedge clk);
        model_step(r, s, cv, id, y, a);
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        logic [3:0] held_i;

        rst = 1; start = 0; cast_valid = 0; cast_id = 0; cast_yes = 0; ballot_ack = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Full turnout on consecutive cycles
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 2, 1, 0);
        cyc(0, 0, 1, 3, 1, 0);
        chk("full_valid", ballot_valid, 1'b1);
        chk("full_I", I, 4'b1101);
        chk("full_to", timed_out, 1'b0);
        chk("full_voted", voted, 4'b1111);
        cyc(0, 0, 0, 0, 0, 1);

        // Timeout with partial turnout
        cyc(0, 1, 0, 0, 0, 0);
        n = 1;
        cyc(0, 0, 1, 1, 1, 0);
        n++;
        cyc(0, 0, 1, 3, 1, 0);
        while (!ballot_valid && n < 40) begin
            n++;
            idle_cyc();
        end
        chk("to_latency", n, TIMEOUT);
        chk("to_I", I, 4'b1010);
        chk("to_flag", timed_out, 1'b1);
        chk("to_voted", voted, 4'b1010);
        cyc(0, 0, 0, 0, 0, 1);

        // Repeat cast
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 2, 1, 0);
        cyc(0, 0, 1, 2, 0, 0);
`ifdef VOTE_REVOTE_EN
        chk("revote_I2", I[2], 1'b0);
        chk("revote_dup", dup_cast, 1'b0);
`else
        chk("dup_I2", I[2], 1'b1);
        chk("dup_pulse", dup_cast, 1'b1);
`endif
        idle_cyc();
        chk("dup_end", dup_cast, 1'b0);
        n = 0;
        while (!ballot_valid && n < 40) begin
            n++;
            idle_cyc();
        end
        chk("dup_closed", ballot_valid, 1'b1);
        cyc(0, 0, 0, 0, 0, 1);

        // Fourth distinct cast lands in the last open cycle
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 2, 0, 0);
        for (int k = 0; k < TIMEOUT - 4; k++) idle_cyc();
        chk("last_still_open", busy, 1'b1);
        cyc(0, 0, 1, 3, 1, 0);
        chk("last_valid", ballot_valid, 1'b1);
        chk("last_to", timed_out, 1'b0);
        chk("last_I", I, 4'b1011);
        chk("last_voted", voted, 4'b1111);

        // DONE holds while acks are withheld, casts ignored
        held_i = I;
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, k % 4, k % 2, 0);
            chk("hold_I", I, held_i);
            chk("hold_valid", ballot_valid, 1'b1);
        end
        cyc(0, 1, 0, 0, 0, 1);
        chk("ackstart_busy", busy, 1'b0);
        chk("ackstart_valid", ballot_valid, 1'b0);
        idle_cyc();
        chk("ackstart_idle", busy, 1'b0);

        // Reset mid-ballot
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_I", I, 4'b0000);
        chk("rst_voted", voted, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("fresh_voted", voted, 4'b0000);
        chk("fresh_busy", busy, 1'b1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
                1'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
